// File: rtl/header_checker_mc.sv
// header_checker_mc
//   Multi-channel package header checker placed after the per-channel ADC
//   package decoders. Each channel compares the received event number and
//   spill number of every package against its expected values, counts
//   packages and erroneous packages, and keeps a sticky error flag. The first
//   failing package of the spill (lowest channel index on ties) is captured
//   for slow-control readout. live_rising clears all per-spill state.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   live_rising       : spill start pulse
//   exp_spillno       : expected spill number (shared by all channels)
//   get_package[c]    : package-valid strobe for channel c
//   pkg_evtno/spillno : flat per-channel header fields
//   evtno_err/spillno_err : result of the last package per channel
//   err_sticky        : any error on the channel this spill
//   in_counter        : packages per channel this spill (wrapping)
//   err_count         : erroneous packages per channel (saturating)
//   first_err_*       : capture of the first failing package of the spill

// One channel of the checker. e_now/s_now are this cycle's raw comparison
// results (gated by get) so the top can run the first-error priority encoder
// without an extra register stage.
module header_checker_lane #(
  parameter int EVTNO_W     = 16,
  parameter int SPILLNO_W   = 10,
  parameter int CNT_W       = 16,
  parameter int ERRCNT_W    = 8,
  parameter int EVTNO_START = 1,
  parameter int RESYNC      = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 get,
  input  logic [EVTNO_W-1:0]   pkg_evtno,
  input  logic [SPILLNO_W-1:0] pkg_spillno,
  input  logic [SPILLNO_W-1:0] exp_spillno,
  output logic                 evtno_err,
  output logic                 spillno_err,
  output logic                 err_sticky,
  output logic [CNT_W-1:0]     in_counter,
  output logic [ERRCNT_W-1:0]  err_count,
  output logic                 e_now,
  output logic                 s_now
);
  localparam logic [EVTNO_W-1:0] START = EVTNO_W'(EVTNO_START);

  logic [EVTNO_W-1:0]  exp_q, exp_cur;
  logic [CNT_W-1:0]    cnt_b;
  logic [ERRCNT_W-1:0] errc_b;
  logic                st_b, ee_b, se_b;

  // A spill start in the same cycle as a package makes that package the
  // first of the new spill: the "base" values below are the already-cleared
  // state, and the package is applied on top of them.
  always_comb begin
    exp_cur = clr ? START : exp_q;
    e_now   = get && (pkg_evtno != exp_cur);
    s_now   = get && (pkg_spillno != exp_spillno);
    cnt_b   = clr ? '0 : in_counter;
    errc_b  = clr ? '0 : err_count;
    st_b    = clr ? 1'b0 : err_sticky;
    ee_b    = clr ? 1'b0 : evtno_err;
    se_b    = clr ? 1'b0 : spillno_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evtno_err   <= 1'b0;
      spillno_err <= 1'b0;
      err_sticky  <= 1'b0;
      in_counter  <= '0;
      err_count   <= '0;
      exp_q       <= START;
    end else if (get) begin
      evtno_err   <= e_now;
      spillno_err <= s_now;
      err_sticky  <= st_b | e_now | s_now;
      in_counter  <= cnt_b + CNT_W'(1);
      err_count   <= ((e_now | s_now) && (errc_b != '1)) ? errc_b + ERRCNT_W'(1) : errc_b;
      exp_q       <= (RESYNC != 0 && e_now) ? pkg_evtno + EVTNO_W'(1)
                                            : exp_cur + EVTNO_W'(1);
    end else begin
      evtno_err   <= ee_b;
      spillno_err <= se_b;
      err_sticky  <= st_b;
      in_counter  <= cnt_b;
      err_count   <= errc_b;
      exp_q       <= exp_cur;
    end
  end
endmodule

module header_checker_mc #(
  parameter int N_CH        = 4,
  parameter int EVTNO_W     = 16,
  parameter int SPILLNO_W   = 10,
  parameter int CNT_W       = 16,
  parameter int ERRCNT_W    = 8,
  parameter int EVTNO_START = 1,
  parameter int RESYNC      = 0,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      live_rising,
  input  logic [SPILLNO_W-1:0]      exp_spillno,
  input  logic [N_CH-1:0]           get_package,
  input  logic [N_CH*EVTNO_W-1:0]   pkg_evtno,
  input  logic [N_CH*SPILLNO_W-1:0] pkg_spillno,
  output logic [N_CH-1:0]           evtno_err,
  output logic [N_CH-1:0]           spillno_err,
  output logic [N_CH-1:0]           err_sticky,
  output logic [N_CH*CNT_W-1:0]     in_counter,
  output logic [N_CH*ERRCNT_W-1:0]  err_count,
  output logic                      first_err_valid,
  output logic [CH_W-1:0]           first_err_ch,
  output logic [EVTNO_W-1:0]        first_err_evtno,
  output logic [1:0]                first_err_type
);
  logic [N_CH-1:0] e_now, s_now;

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    header_checker_lane #(
      .EVTNO_W(EVTNO_W), .SPILLNO_W(SPILLNO_W), .CNT_W(CNT_W),
      .ERRCNT_W(ERRCNT_W), .EVTNO_START(EVTNO_START), .RESYNC(RESYNC)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .clr         (live_rising),
      .get         (get_package[c]),
      .pkg_evtno   (pkg_evtno[c*EVTNO_W +: EVTNO_W]),
      .pkg_spillno (pkg_spillno[c*SPILLNO_W +: SPILLNO_W]),
      .exp_spillno (exp_spillno),
      .evtno_err   (evtno_err[c]),
      .spillno_err (spillno_err[c]),
      .err_sticky  (err_sticky[c]),
      .in_counter  (in_counter[c*CNT_W +: CNT_W]),
      .err_count   (err_count[c*ERRCNT_W +: ERRCNT_W]),
      .e_now       (e_now[c]),
      .s_now       (s_now[c])
    );
  end

  // Lowest-index erring channel this cycle. Outputs stay zero when no
  // channel errs, which lets the capture register load them unconditionally
  // while it is still open.
  logic               hit;
  logic [CH_W-1:0]    win_ch;
  logic [EVTNO_W-1:0] win_ev;
  logic [1:0]         win_ty;

  always_comb begin
    hit    = 1'b0;
    win_ch = '0;
    win_ev = '0;
    win_ty = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (!hit && (e_now[c] || s_now[c])) begin
        hit    = 1'b1;
        win_ch = CH_W'(c);
        win_ev = pkg_evtno[c*EVTNO_W +: EVTNO_W];
        win_ty = {s_now[c], e_now[c]};
      end
    end
  end

  // Capture stays open until the first error; a spill start reopens it and
  // takes this cycle's packages as the first of the new spill.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_err_valid <= 1'b0;
      first_err_ch    <= '0;
      first_err_evtno <= '0;
      first_err_type  <= '0;
    end else if (live_rising || !first_err_valid) begin
      first_err_valid <= hit;
      first_err_ch    <= win_ch;
      first_err_evtno <= win_ev;
      first_err_type  <= win_ty;
    end
  end
endmodule

// File: tb/tb_header_checker_mc.sv
// Randomised + directed bench for header_checker_mc. Two instances share one
// stimulus stream: RESYNC=0 (index 0) and RESYNC=1 (index 1). A per-spill
// reference model written with plain integer arithmetic predicts every output.
module tb_header_checker_mc;
  localparam int N_CH = 4, EW = 16, SW = 10, CW = 16, ECW = 8, START = 1;
  localparam int EMASK = (1 << EW) - 1, CMASK = (1 << CW) - 1, ECMAX = (1 << ECW) - 1;
  localparam int CHW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_i, lr;
  logic [SW-1:0]        xsp;
  logic [N_CH-1:0]      gp;
  logic [N_CH*EW-1:0]   ev_f;
  logic [N_CH*SW-1:0]   sp_f;
  int                   ev[N_CH], sp[N_CH];

  logic [N_CH-1:0]      o_ee[2], o_se[2], o_st[2];
  logic [N_CH*CW-1:0]   o_cnt[2];
  logic [N_CH*ECW-1:0]  o_ec[2];
  logic                 o_fv[2];
  logic [CHW-1:0]       o_fc[2];
  logic [EW-1:0]        o_fe[2];
  logic [1:0]           o_ft[2];

  for (genvar r = 0; r < 2; r++) begin : g_dut
    header_checker_mc #(.N_CH(N_CH), .EVTNO_W(EW), .SPILLNO_W(SW), .CNT_W(CW),
                        .ERRCNT_W(ECW), .EVTNO_START(START), .RESYNC(r)) dut (
      .clk(clk), .rst(rst_i), .live_rising(lr), .exp_spillno(xsp),
      .get_package(gp), .pkg_evtno(ev_f), .pkg_spillno(sp_f),
      .evtno_err(o_ee[r]), .spillno_err(o_se[r]), .err_sticky(o_st[r]),
      .in_counter(o_cnt[r]), .err_count(o_ec[r]),
      .first_err_valid(o_fv[r]), .first_err_ch(o_fc[r]),
      .first_err_evtno(o_fe[r]), .first_err_type(o_ft[r]));
  end

  always_comb begin
    ev_f = '0;
    sp_f = '0;
    for (int c = 0; c < N_CH; c++) begin
      ev_f[c*EW +: EW] = EW'(ev[c]);
      sp_f[c*SW +: SW] = SW'(sp[c]);
    end
  end

  // ---------------- reference model ----------------
  int m_exp[2][N_CH], m_cnt[2][N_CH], m_ec[2][N_CH];
  int m_ee[2][N_CH], m_se[2][N_CH], m_st[2][N_CH];
  int m_fv[2], m_fc[2], m_fe[2], m_ft[2];

  function automatic void model_clear(int r);
    for (int c = 0; c < N_CH; c++) begin
      m_exp[r][c] = START; m_cnt[r][c] = 0; m_ec[r][c] = 0;
      m_ee[r][c] = 0; m_se[r][c] = 0; m_st[r][c] = 0;
    end
    m_fv[r] = 0; m_fc[r] = 0; m_fe[r] = 0; m_ft[r] = 0;
  endfunction

  // Spill start clears first; packages of the same cycle then belong to the
  // new spill. Capture takes the lowest channel that errs while still open.
  function automatic void model_step();
    for (int r = 0; r < 2; r++) begin
      if (rst_i) begin
        model_clear(r);
        continue;
      end
      if (lr) model_clear(r);
      for (int c = 0; c < N_CH; c++) begin
        if (gp[c]) begin
          int e, s;
          e = (ev[c] != m_exp[r][c]);
          s = (sp[c] != int'(xsp));
          m_ee[r][c] = e; m_se[r][c] = s;
          m_cnt[r][c] = (m_cnt[r][c] + 1) & CMASK;
          if (e || s) begin
            if (m_ec[r][c] < ECMAX) m_ec[r][c]++;
            m_st[r][c] = 1;
            if (!m_fv[r]) begin
              m_fv[r] = 1; m_fc[r] = c; m_fe[r] = ev[c]; m_ft[r] = 2 * s + e;
            end
          end
          m_exp[r][c] = ((r == 1 && e) ? ev[c] + 1 : m_exp[r][c] + 1) & EMASK;
        end
      end
    end
  endfunction

  // ---------------- checking ----------------
  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < N_CH; c++) begin
        chk($sformatf("d%0d_evtno_err%0d", r, c), 32'(o_ee[r][c]), m_ee[r][c]);
        chk($sformatf("d%0d_spillno_err%0d", r, c), 32'(o_se[r][c]), m_se[r][c]);
        chk($sformatf("d%0d_sticky%0d", r, c), 32'(o_st[r][c]), m_st[r][c]);
        chk($sformatf("d%0d_cnt%0d", r, c), 32'(o_cnt[r][c*CW +: CW]), m_cnt[r][c]);
        chk($sformatf("d%0d_errcnt%0d", r, c), 32'(o_ec[r][c*ECW +: ECW]), m_ec[r][c]);
      end
      chk($sformatf("d%0d_fe_valid", r), 32'(o_fv[r]), m_fv[r]);
      chk($sformatf("d%0d_fe_ch", r), 32'(o_fc[r]), m_fc[r]);
      chk($sformatf("d%0d_fe_evtno", r), 32'(o_fe[r]), m_fe[r]);
      chk($sformatf("d%0d_fe_type", r), 32'(o_ft[r]), m_ft[r]);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    rst_i = 1'b0; lr = 1'b0; gp = '0;
  endtask

  task automatic pkg(input int c, input int e, input int s);
    gp[c] = 1'b1; ev[c] = e; sp[c] = s;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    idle();
  endtask

  initial begin
    for (int c = 0; c < N_CH; c++) begin ev[c] = 0; sp[c] = 0; end
    idle();
    xsp = 10'd5;
    for (int r = 0; r < 2; r++) model_clear(r);

    // reset state
    rst_i = 1'b1; step();
    rst_i = 1'b1; step();
    for (int r = 0; r < 2; r++) chk($sformatf("d%0d_rst_fv", r), 32'(o_fv[r]), 0);

    // nominal: evtno 1..100 on every channel
    lr = 1'b1; step();
    for (int i = 1; i <= 100; i++) begin
      for (int c = 0; c < N_CH; c++) pkg(c, i, 5);
      step();
    end
    for (int c = 0; c < N_CH; c++) chk($sformatf("nom_cnt%0d", c), 32'(o_cnt[0][c*CW +: CW]), 100);
    chk("nom_fv", 32'(o_fv[0]), 0);
    chk("nom_sticky", 32'(o_st[0]), 0);

    // skipped event on ch2: 1,2,4,5
    lr = 1'b1; step();
    pkg(2, 1, 5); step();
    pkg(2, 2, 5); step();
    pkg(2, 4, 5); step();
    chk("skip_r0_ee4", 32'(o_ee[0][2]), 1);
    chk("skip_r1_ee4", 32'(o_ee[1][2]), 1);
    pkg(2, 5, 5); step();
    chk("skip_r0_ee5", 32'(o_ee[0][2]), 1);
    chk("skip_r1_ee5", 32'(o_ee[1][2]), 0);
    chk("skip_r0_errcnt", 32'(o_ec[0][2*ECW +: ECW]), 2);
    chk("skip_r1_errcnt", 32'(o_ec[1][2*ECW +: ECW]), 1);
    chk("skip_r1_fe_ch", 32'(o_fc[1]), 2);
    chk("skip_r1_fe_evtno", 32'(o_fe[1]), 4);
    chk("skip_r1_fe_type", 32'(o_ft[1]), 1);

    // simultaneous spillno errors on ch1 and ch3
    lr = 1'b1; step();
    for (int c = 0; c < N_CH; c++) pkg(c, 1, 5);
    step();
    for (int c = 0; c < N_CH; c++) pkg(c, 2, (c == 1 || c == 3) ? 6 : 5);
    step();
    chk("simul_fe_ch", 32'(o_fc[0]), 1);
    chk("simul_fe_type", 32'(o_ft[0]), 2);
    pkg(0, 3, 6); step();
    chk("simul_later_fe_ch", 32'(o_fc[0]), 1);
    chk("simul_later_fe_evtno", 32'(o_fe[0]), 2);

    // evtno wrap on ch0 (resync instance lands on 65535 first)
    lr = 1'b1; step();
    pkg(0, 65534, 5); step();
    pkg(0, 65535, 5); step();
    chk("wrap_65535_ee", 32'(o_ee[1][0]), 0);
    pkg(0, 0, 5); step();
    chk("wrap_0_ee", 32'(o_ee[1][0]), 0);
    // saturation: 300 bad packages on ch1
    for (int i = 0; i < 300; i++) begin
      pkg(1, 1 + i, 7); step();
    end
    chk("sat_r0", 32'(o_ec[0][1*ECW +: ECW]), 255);
    chk("sat_r1", 32'(o_ec[1][1*ECW +: ECW]), 255);

    // spill start coincident with a good ch0 package, after errors
    lr = 1'b1; pkg(0, 1, 5); step();
    chk("lr_cnt0", 32'(o_cnt[0][0 +: CW]), 1);
    chk("lr_sticky", 32'(o_st[0]), 0);
    chk("lr_fv", 32'(o_fv[0]), 0);
    for (int c = 1; c < N_CH; c++) chk($sformatf("lr_cnt%0d", c), 32'(o_cnt[0][c*CW +: CW]), 0);

    // reset mid-spill together with packages
    pkg(2, 9, 3); step();
    rst_i = 1'b1;
    for (int c = 0; c < N_CH; c++) pkg(c, 3, 5);
    step();
    chk("rst_cnt", 32'(o_cnt[0]), 0);
    chk("rst_fv", 32'(o_fv[0]), 0);
    pkg(0, START, 5); step();
    chk("rst_next_ee", 32'(o_ee[0][0]), 0);
    chk("rst_next_cnt", 32'(o_cnt[0][0 +: CW]), 1);

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      rst_i = ($urandom_range(0, 499) == 0);
      lr    = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 199) == 0) xsp = SW'($urandom_range(0, 7));
      for (int c = 0; c < N_CH; c++) begin
        gp[c] = $urandom_range(0, 1);
        ev[c] = ($urandom_range(0, 3) != 0) ? m_exp[$urandom_range(0, 1)][c]
                                             : int'($urandom_range(0, EMASK));
        sp[c] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) : int'(xsp);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/header_checker_mc.md
# header_checker_mc

Multi-channel, parametrised successor of the single-channel package header checker. It sits after the per-channel ADC package decoders. It checks every received package header (event number, spill number) against expected values on each channel independently. It also keeps per-channel package and error counts, and captures the first failing package of the spill for slow-control readout. All per-spill state is cleared on `live_rising`.

## Interface
Parameters:
- `N_CH`, 4: number of independent channels (1..16).
- `EVTNO_W`, 16: event number width.
- `SPILLNO_W`, 10: spill number width.
- `CNT_W`, 16: per-channel package counter width.
- `ERRCNT_W`, 8: per-channel error counter width (saturating).
- `EVTNO_START`, 1: expected event number of the first package in a spill.
- `RESYNC`, 0: 0 = expected evtno always increments by 1; 1 = after an evtno mismatch, expected evtno resynchronises to `pkg_evtno+1`.

Ports:
- `clk`, in, 1: system clock; all logic on its rising edge.
- `rst`, in, 1: reset; synchronous, active-high.
- `live_rising`, in, 1: spill start pulse; clears per-spill state.
- `exp_spillno`, in, SPILLNO_W: expected spill number, shared by all channels.
- `get_package`, in, N_CH: per-channel one-cycle package-valid strobe.
- `pkg_evtno`, in, N_CH*EVTNO_W: channel c in bits [c*EVTNO_W +: EVTNO_W].
- `pkg_spillno`, in, N_CH*SPILLNO_W: channel c in bits [c*SPILLNO_W +: SPILLNO_W].
- `evtno_err`, out, N_CH: result of the last package on each channel.
- `spillno_err`, out, N_CH: result of the last package on each channel.
- `err_sticky`, out, N_CH: set by any evtno or spillno error on the channel in this spill.
- `in_counter`, out, N_CH*CNT_W: packages received per channel this spill.
- `err_count`, out, N_CH*ERRCNT_W: packages with any error per channel; saturates.
- `first_err_valid`, out, 1: a first error has been captured this spill.
- `first_err_ch`, out, clog2(N_CH) (min 1): channel of the captured error.
- `first_err_evtno`, out, EVTNO_W: `pkg_evtno` of the captured package.
- `first_err_type`, out, 2: {spillno_err, evtno_err} of the captured package.

## Operation
- Reset (`rst`=1): all outputs go to 0, and every internal `exp_evtno[c]` goes to EVTNO_START. `rst` overrides `live_rising` and `get_package` in the same cycle.
- `live_rising`=1 alone has the same effect as reset on all outputs and `exp_evtno`.
- Per channel c, on `get_package[c]`=1:
  - `evtno_err[c]` <= (`pkg_evtno[c]` != `exp_evtno[c]`).
  - `spillno_err[c]` <= (`pkg_spillno[c]` != `exp_spillno`).
  - `in_counter[c]` increments, wrapping mod 2^CNT_W.
  - If either error is set: `err_count[c]` increments, holding at 2^ERRCNT_W-1; `err_sticky[c]` is set.
  - `exp_evtno[c]` <= `exp_evtno[c]`+1, wrapping mod 2^EVTNO_W. With RESYNC=1 and an evtno mismatch, it becomes `pkg_evtno[c]`+1 instead.
- With `get_package[c]`=0, channel c holds all its state, including `evtno_err`/`spillno_err`.
- First-error capture: the first cycle in the spill in which any channel errs loads `first_err_*` and sets `first_err_valid`. If several channels err in that cycle, the lowest index wins. Once valid, the capture is frozen until `live_rising` or `rst`.
- `live_rising` and `get_package[c]` in the same cycle: the package is the first of the new spill.
  - It is checked against EVTNO_START and the current `exp_spillno`.
  - `in_counter[c]`=1 and `exp_evtno[c]`=EVTNO_START+1 (or the resync value).
  - `err_count[c]` is 0 or 1; `err_sticky[c]` and the first-error capture reflect only this package.
  - Non-strobed channels clear.
- Channels are fully independent. Simultaneous strobes on all N_CH channels are processed in one cycle.

## Timing
- All outputs are registered. The result of a package strobed in cycle n is visible in cycle n+1.
- Back-to-back strobes every cycle on a channel are supported. There is no backpressure.
- `exp_spillno` is sampled in the same cycle as `get_package`.
- The first-error capture has the same one-cycle latency as the error flags.
- Comparisons and the priority encoder must close timing at the system clock with N_CH=16. A single level of registering is required; no extra pipeline stage is allowed.

## Test plan
- Nominal sequence: N_CH=4, `exp_spillno`=5. Each channel receives evtno 1..100 with spillno 5. Expect `in_counter`=100 on each channel, all err outputs 0, and `first_err_valid`=0.
- Skipped event: ch2 receives 1,2,4,5.
  - RESYNC=0: `evtno_err[2]`=1 on packages 4 and 5; `err_count[2]`=2.
  - RESYNC=1: only package 4 errs; `err_count[2]`=1; `first_err_ch`=2, `first_err_evtno`=4, `first_err_type`=2'b01.
- Simultaneous errors: ch1 and ch3 send spillno 6 in the same cycle, `exp_spillno`=5. Expect `first_err_ch`=1, `first_err_type`=2'b10. A later error on ch0 leaves the capture unchanged.
- Wrap and saturation: EVTNO_W=16, ch0 runs from evtno 65535 to 0 with matching expectation, giving no error. ERRCNT_W=8 with 300 bad packages gives `err_count`=255.
- `live_rising` coincident with a ch0 package of evtno 1, after a spill with errors: cycle+1 shows `in_counter[0]`=1, `err_sticky`=0, `first_err_valid`=0, and other channels' counters at 0.
- `rst` asserted mid-spill together with `get_package`: all outputs 0 at cycle+1. The next package with evtno EVTNO_START passes.
